// File: rtl/seq_stepper_pkg.sv
// Shared types and helpers for the table-driven pattern stepper.
package seq_stepper_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'd0,
        MODE_SAT    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_RSVD   = 2'd3
    } step_mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Reset contents of entry i: i mod 2^width.
    function automatic int default_entry(input int i, input int width);
        if (width >= 31) return i;
        return i % (1 << width);
    endfunction

endpackage

// File: rtl/seq_stepper_table.sv
// DEPTH x WIDTH pattern table: one write port, one combinational read port.
module seq_table
    import seq_stepper_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic                        w_wr_ok;

    assign w_wr_ok = wr_en && (32'(wr_addr) < DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= WIDTH'(default_entry(i, WIDTH));
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/seq_stepper.sv
// Up/down pattern sequencer walking a writable table with wrap/saturate/bounce ends.
module seq_stepper
    import seq_stepper_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] value,
    output logic [IDX_W-1:0] index,
    output logic             edge_evt
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0] r_idx;
    logic             r_dir;
    logic [WIDTH-1:0] r_value;
    logic             r_evt;

    logic [IDX_W-1:0] w_nxt_idx;
    logic             w_nxt_dir;
    logic             w_evt;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_wr_hit;
    logic [WIDTH-1:0] w_rd_data;

    assign w_at_top = (r_idx == LAST);
    assign w_at_bot = (r_idx == '0);

    always_comb begin
        w_nxt_idx = r_idx;
        w_nxt_dir = r_dir;
        w_evt     = 1'b0;
        if (load) begin
            // An out-of-range load still wins over stepping; it just has no effect.
            if (32'(load_idx) < DEPTH)
                w_nxt_idx = load_idx;
        end else if (en) begin
            case (step_mode_e'(mode))
                MODE_SAT: begin
                    if (up) begin
                        if (w_at_top) w_evt = 1'b1;
                        else          w_nxt_idx = r_idx + 1'b1;
                    end else begin
                        if (w_at_bot) w_evt = 1'b1;
                        else          w_nxt_idx = r_idx - 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    if (r_dir == DIR_UP) begin
                        if (w_at_top) begin
                            w_nxt_dir = DIR_DOWN;
                            w_nxt_idx = LAST - 1'b1;
                            w_evt     = 1'b1;
                        end else begin
                            w_nxt_idx = r_idx + 1'b1;
                        end
                    end else begin
                        if (w_at_bot) begin
                            w_nxt_dir = DIR_UP;
                            w_nxt_idx = IDX_W'(1);
                            w_evt     = 1'b1;
                        end else begin
                            w_nxt_idx = r_idx - 1'b1;
                        end
                    end
                end
                default: begin
                    if (up) begin
                        w_nxt_idx = w_at_top ? '0 : r_idx + 1'b1;
                        w_evt     = w_at_top;
                    end else begin
                        w_nxt_idx = w_at_bot ? LAST : r_idx - 1'b1;
                        w_evt     = w_at_bot;
                    end
                end
            endcase
        end
    end

    // Read the entry the pointer lands on; a same-edge write to it bypasses the table.
    seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (w_nxt_idx),
        .rd_data (w_rd_data)
    );

    assign w_wr_hit = wr_en && (32'(wr_addr) < DEPTH) && (wr_addr == w_nxt_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_dir   <= DIR_UP;
            r_value <= '0;
            r_evt   <= 1'b0;
        end else begin
            r_idx   <= w_nxt_idx;
            r_dir   <= w_nxt_dir;
            r_evt   <= w_evt;
            r_value <= w_wr_hit ? wr_data : w_rd_data;
        end
    end

    assign value    = r_value;
    assign index    = r_idx;
    assign edge_evt = r_evt;

endmodule

// File: tb/tb_seq_stepper.sv
// Directed bench for seq_stepper: per-cycle model compare on DEPTH=8 plus literal checks on DEPTH=8/4/6.
module tb_seq_stepper;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, load, wr_en;
    logic [1:0] mode;
    logic [2:0] load_idx, wr_addr;
    logic [3:0] wr_data;
    logic [3:0] value;
    logic [2:0] index;
    logic       edge_evt;

    // shared inputs for the DEPTH=4 and DEPTH=6 instances
    logic       en_b, up_b, load_b, wr_b;
    logic [1:0] mode_b;
    logic [1:0] ld4, wa4;
    logic [2:0] ld6, wa6;
    logic [3:0] wd_b;
    logic [3:0] v4, v6;
    logic [1:0] i4;
    logic [2:0] i6;
    logic       e4, e6;

    int  errs   = 0;
    int  checks = 0;
    bit  chk_on = 1'b0;

    int exp1[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int tab2[8] = '{4, 8, 12, 0, 3, 7, 11, 15};
    int exp2[5] = '{12, 8, 4, 15, 11};
    int exp3[5] = '{6, 7, 7, 7, 7};
    int exp4[8] = '{1, 2, 3, 2, 1, 0, 1, 2};

    always #5 clk = ~clk;

    seq_stepper #(.WIDTH(4), .DEPTH(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .load(load),
        .load_idx(load_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .value(value), .index(index), .edge_evt(edge_evt)
    );

    seq_stepper #(.WIDTH(4), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en_b), .up(up_b), .mode(mode_b), .load(load_b),
        .load_idx(ld4), .wr_en(wr_b), .wr_addr(wa4), .wr_data(wd_b),
        .value(v4), .index(i4), .edge_evt(e4)
    );

    seq_stepper #(.WIDTH(4), .DEPTH(6)) u_dut6 (
        .clk(clk), .rst(rst), .en(en_b), .up(up_b), .mode(mode_b), .load(load_b),
        .load_idx(ld6), .wr_en(wr_b), .wr_addr(wa6), .wr_data(wd_b),
        .value(v6), .index(i6), .edge_evt(e6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the DEPTH=8 instance. Bounce is tracked as a phase around a 2*D-2 cycle.
    int m_idx, m_val, m_tab[8];
    bit m_dir, m_evt;
    int mn, mp, mstep;
    localparam int PER = 2 * D - 2;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idx = 0; m_dir = 1'b1; m_val = 0; m_evt = 1'b0;
            for (int i = 0; i < D; i++) m_tab[i] = i % 16;
        end else begin
            mn    = m_idx;
            m_evt = 1'b0;
            mstep = up ? 1 : -1;
            if (load) begin
                if (int'(load_idx) < D) mn = int'(load_idx);
            end else if (en) begin
                case (mode)
                    2'd1: begin
                        if (m_idx + mstep < 0 || m_idx + mstep > D - 1) m_evt = 1'b1;
                        else mn = m_idx + mstep;
                    end
                    2'd2: begin
                        mp = m_dir ? m_idx : (PER - m_idx) % PER;
                        mp = (mp + 1) % PER;
                        mn = (mp < D) ? mp : PER - mp;
                        if ((mp >= 1 && mp <= D - 1) != m_dir) m_evt = 1'b1;
                        m_dir = (mp >= 1 && mp <= D - 1);
                    end
                    default: begin
                        mn    = (m_idx + mstep + D) % D;
                        m_evt = (m_idx + mstep) != mn;
                    end
                endcase
            end
            if (wr_en && int'(wr_addr) < D) m_tab[wr_addr] = int'(wr_data);
            m_idx = mn;
            m_val = m_tab[m_idx];
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmp_value", 32'(value), 32'(m_val));
            chk("cmp_index", 32'(index), 32'(m_idx));
            chk("cmp_evt",   32'(edge_evt), 32'(m_evt));
        end
    end

    initial begin
        en = 0; up = 0; load = 0; wr_en = 0; mode = 0; load_idx = 0; wr_addr = 0; wr_data = 0;
        en_b = 0; up_b = 0; load_b = 0; wr_b = 0; mode_b = 0; ld4 = 0; wa4 = 0; ld6 = 0; wa6 = 0; wd_b = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_value", 32'(value), 0);
        chk("rst_index", 32'(index), 0);
        chk("rst_evt",   32'(edge_evt), 0);
        chk("rst_index4", 32'(i4), 0);
        chk("rst_value6", 32'(v6), 0);
        rst = 1'b1;
        chk_on = 1'b1;

        // wrap up through the end of the table
        mode = 2'd0; up = 1; en = 1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            chk("t1_value", 32'(value), 32'(exp1[k]));
            chk("t1_evt",   32'(edge_evt), 32'(k == 7));
        end
        @(negedge clk); en = 0;

        // rewrite table, load 3, wrap down
        for (int a = 0; a < 8; a++) begin
            wr_en = 1; wr_addr = 3'(a); wr_data = 4'(tab2[a]);
            @(negedge clk);
        end
        wr_en = 0; load = 1; load_idx = 3;
        @(negedge clk); load = 0; up = 0; en = 1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("t2_value", 32'(value), 32'(exp2[k]));
            chk("t2_evt",   32'(edge_evt), 32'(k == 3));
        end
        @(negedge clk); en = 0;

        // saturate pinned at the top
        load = 1; load_idx = 5; mode = 2'd1; up = 1;
        @(negedge clk); load = 0; en = 1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("t3_index", 32'(index), 32'(exp3[k]));
            chk("t3_evt",   32'(edge_evt), 32'(k >= 2));
        end
        @(negedge clk); en = 0;

        // write-through and load priority
        load = 1; load_idx = 2; mode = 2'd0;
        @(negedge clk); load = 0; en = 1; up = 1; wr_en = 1; wr_addr = 3; wr_data = 9;
        @(posedge clk); #1;
        chk("t5_wt_value", 32'(value), 9);
        chk("t5_wt_index", 32'(index), 3);
        @(negedge clk); wr_en = 0; load = 1; load_idx = 6;
        @(posedge clk); #1;
        chk("t5_load_index", 32'(index), 6);
        chk("t5_load_value", 32'(value), 11);
        chk("t5_load_evt",   32'(edge_evt), 0);
        @(negedge clk); load = 0; en = 0; wr_en = 1; wr_addr = 0; wr_data = 13;
        @(posedge clk); #1;
        chk("t5_far_write_value", 32'(value), 11);
        @(negedge clk); wr_en = 0; load = 1; load_idx = 0;
        @(posedge clk); #1;
        chk("t5_far_write_later", 32'(value), 13);

        // bounce off the top, then reset mid-cycle
        @(negedge clk); load = 1; load_idx = 7; mode = 2'd2;
        @(negedge clk); load = 0; en = 1;
        @(posedge clk); #1;
        chk("t6_turn_index", 32'(index), 6);
        chk("t6_turn_evt",   32'(edge_evt), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("t6_async_index", 32'(index), 0);
        chk("t6_async_value", 32'(value), 0);
        chk("t6_async_evt",   32'(edge_evt), 0);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_first_index", 32'(index), 1);
        chk("t6_first_value", 32'(value), 1);
        chk("t6_first_evt",   32'(edge_evt), 0);
        @(posedge clk); #1;
        chk("t6_second_index", 32'(index), 2);
        @(negedge clk); en = 0;

        // DEPTH=4 bounce, up ignored
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); en_b = 1; mode_b = 2'd2; up_b = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("t4_index", 32'(i4), 32'(exp4[k]));
            chk("t4_evt",   32'(e4), 32'(k == 3 || k == 6));
        end

        // DEPTH=6: out-of-range load ignored, wrap at 5
        @(negedge clk); en_b = 0; load_b = 1; ld6 = 4;
        @(posedge clk); #1;
        chk("t7_load_index", 32'(i6), 4);
        @(negedge clk); ld6 = 7; en_b = 1;
        @(posedge clk); #1;
        chk("t7_bad_load_index", 32'(i6), 4);
        chk("t7_bad_load_evt",   32'(e6), 0);
        @(negedge clk); load_b = 0; mode_b = 2'd0; up_b = 1;
        @(posedge clk); #1;
        chk("t7_step_index", 32'(i6), 5);
        chk("t7_step_value", 32'(v6), 5);
        @(posedge clk); #1;
        chk("t7_wrap_index", 32'(i6), 0);
        chk("t7_wrap_value", 32'(v6), 0);
        chk("t7_wrap_evt",   32'(e6), 1);
        @(negedge clk); en_b = 0;

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
